// File: rtl/vermibus_arbiter.sv
// ---------------------------------------------------------------------------
// vermibus_arbiter
//
// Shares one Vermibus responder between two requesters (typically the CPU
// data bus on port 0 and a DMA/debug master on port 1). One requester is
// granted at a time. Its request is forwarded to the responder, and the
// responder's ready/rdata are routed back to it. A watchdog force-completes
// any transaction the responder leaves hanging for TIMEOUT_CYCLES cycles.
//
// Parameters
//   PRIORITY_MODE   0: round-robin, 1: fixed priority (requester 0 highest)
//   TIMEOUT_CYCLES  granted cycles without s_ready before forced completion
//                   (2..65535)
//
// Ports
//   clk, reset                  system clock, async active-low reset
//   m0_* / m1_*                 requester ports (valid/address/wstrobe/wdata
//                               in, ready/rdata out)
//   s_valid/address/wstrobe/
//   s_wdata                     forwarded request to the responder
//   s_rdata, s_ready            responder read data and completion
//   owner                       debug: 00 idle, 01 req 0 granted, 10 req 1
//   timeout                     one-cycle pulse when the watchdog fires
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no grant; arbitrate among the valid requesters
// ST_GRANT0 | requester 0 owns the responder
// ST_GRANT1 | requester 1 owns the responder
// ---------------------------------------------------------------------------
module vermibus_arbiter #(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_address,
    input  logic [3:0]  m0_wstrobe,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_wstrobe,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_address,
    output logic [3:0]  s_wstrobe,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    output logic [1:0]  owner,
    output logic        timeout
);

    // Encodings double as the owner debug value.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_GRANT0 = 2'b01;
    localparam logic [1:0] ST_GRANT1 = 2'b10;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last_owner;
    logic        last_owner_nxt;
    logic [15:0] wd_count;
    logic [15:0] wd_count_nxt;

    logic        fixed_prio;
    logic        in_grant0;
    logic        in_grant1;
    logic        cur_valid;
    logic        done_ok;
    logic        wd_fire;

    assign fixed_prio = (PRIORITY_MODE != 0);
    assign in_grant0  = (state == ST_GRANT0);
    assign in_grant1  = (state == ST_GRANT1);

    // Owner's valid; dropping it mid-grant is treated as an abort, so both
    // completion paths require it.
    assign cur_valid = (in_grant0 & m0_valid) | (in_grant1 & m1_valid);

    // s_ready wins over the watchdog when both land on the same cycle.
    assign done_ok = cur_valid & s_ready;
    assign wd_fire = cur_valid & ~s_ready & (wd_count == WD_LAST);

    // Responder side.
    always_comb begin
        s_valid   = cur_valid & ~wd_fire;
        s_address = 32'h0;
        s_wstrobe = 4'h0;
        s_wdata   = 32'h0;
        if (in_grant0) begin
            s_address = m0_address;
            s_wstrobe = m0_wstrobe;
            s_wdata   = m0_wdata;
        end else if (in_grant1) begin
            s_address = m1_address;
            s_wstrobe = m1_wstrobe;
            s_wdata   = m1_wdata;
        end
    end

    // Requester side. rdata is only driven on a genuine completion; a
    // watchdog completion returns zero.
    assign m0_ready = in_grant0 & (done_ok | wd_fire);
    assign m1_ready = in_grant1 & (done_ok | wd_fire);
    assign m0_rdata = (in_grant0 & done_ok) ? s_rdata : 32'h0;
    assign m1_rdata = (in_grant1 & done_ok) ? s_rdata : 32'h0;
    assign timeout  = wd_fire;
    assign owner    = state;

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        wd_count_nxt   = wd_count;
        case (state)
            ST_IDLE: begin
                wd_count_nxt = 16'h0;
                if (m0_valid && m1_valid) begin
                    // Round-robin: favour whoever did not finish last.
                    if (fixed_prio || last_owner)
                        state_nxt = ST_GRANT0;
                    else
                        state_nxt = ST_GRANT1;
                end else if (m0_valid) begin
                    state_nxt = ST_GRANT0;
                end else if (m1_valid) begin
                    state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!cur_valid) begin
                    state_nxt = ST_IDLE;
                end else if (done_ok || wd_fire) begin
                    state_nxt      = ST_IDLE;
                    last_owner_nxt = in_grant1;
                end else begin
                    wd_count_nxt = wd_count + 16'h1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            wd_count   <= 16'h0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            wd_count   <= wd_count_nxt;
        end
    end

endmodule
